fetch_stage: RTL

- Instruction-fetch stage. Owns the program counter and drives the address into the synchronous block-RAM instruction memory. That memory has one cycle of read latency and maps byte address IM_BASE to word 0.
- Pairs each returned word with the PC that produced it and presents both to decode.
- Handles decode stalls, branch/jump redirects, the exception-handler vector and PC address faults. Decode never receives a word that does not belong to the PC shown beside it.

---
 rtl/fetch_stage.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency instruction RAM, pairs each word with its PC.
// Redirect/exception target appears on if_instr one cycle after acceptance; stall re-presents pc_q.
module fetch_stage #(
  parameter logic [31:0] PC_RESET     = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE      = 32'h0000_3000,
  parameter int          IM_ADDR_BITS = 13
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_adel
);

  localparam logic [31:0] IM_LAST = IM_BASE + (32'd4 << IM_ADDR_BITS) - 32'd4;

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        fault;
  logic        take;

  assign fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
  assign take  = exc_req || redirect;

  // A faulting PC is held even in RUN so the stage never walks past a bad address.
  always_comb begin
    next_pc = pc_q;
    if (state_q != BOOT) begin
      if (exc_req)
        next_pc = HANDLER_PC;
      else if (redirect)
        next_pc = redirect_pc;
      else if (stall || fault || state_q == FAULT)
        next_pc = pc_q;
      else
        next_pc = pc_q + 32'd4;
    end
  end

  always_comb begin
    im_addr  = next_pc;
    if_pc    = pc_q;
    if_valid = 1'b0;
    if_adel  = 1'b0;
    if_instr = 32'd0;
    if (reset) begin
      im_addr = PC_RESET;
      if_pc   = PC_RESET;
    end else begin
      case (state_q)
        RUN: begin
          if_valid = 1'b1;
          if_adel  = fault;
          if_instr = fault ? 32'd0 : im_rdata;
        end
        FAULT: begin
          if_valid = 1'b1;
          if_adel  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      state_q <= BOOT;
    end else begin
      pc_q <= next_pc;
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= (fault && !take) ? FAULT : RUN;
        FAULT:   state_q <= take ? RUN : FAULT;
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule
